// File: rtl/demux_1_to_4_pkg.sv
// Shared constants and select decode for the 1-to-4 registered demultiplexer.
package demux_1_to_4_pkg;

  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned SEL_W     = 2;

  // One-hot decode of a lane index.
  function automatic logic [NUM_LANES-1:0] onehot4(input logic [SEL_W-1:0] sel);
    logic [NUM_LANES-1:0] oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/demux_1_to_4_lane_counter.sv
// Per-lane saturating transfer counter with synchronous clear.
module demux_lane_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  // Clear wins over increment; the count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/demux_1_to_4.sv
// Registered 1-to-4 demultiplexer with per-lane valid flags and transfer counters.
module demux_1_to_4
  import demux_1_to_4_pkg::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [WIDTH-1:0]             in,
  input  logic                         in_valid,
  input  logic [SEL_W-1:0]             select,
  output logic [NUM_LANES*WIDTH-1:0]   out,
  output logic [NUM_LANES-1:0]         out_valid,
  output logic [NUM_LANES*CNT_W-1:0]   cnt,
  input  logic                         cnt_clr
);

  localparam int unsigned OUT_W = NUM_LANES * WIDTH;

  logic [OUT_W-1:0]     out_d;
  logic [NUM_LANES-1:0] lane_oh;
  logic [NUM_LANES-1:0] valid_d;

  // Only the selected lane carries data; every other lane is forced to zero.
  always_comb begin
    out_d   = '0;
    lane_oh = onehot4(select);
    for (int k = 0; k < int'(NUM_LANES); k++) begin
      if (lane_oh[k]) begin
        out_d[k*WIDTH +: WIDTH] = in;
      end
    end
    valid_d = in_valid ? lane_oh : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= '0;
    end else begin
      out       <= out_d;
      out_valid <= valid_d;
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_cnt
    demux_lane_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .inc   (valid_d[g]),
      .cnt   (cnt[g*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_demux_1_to_4.sv
// Bench for demux_1_to_4: a 1-bit/8-bit-counter instance and an 8-bit/2-bit-counter instance share stimulus.
module tb_demux_1_to_4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  din;
  logic        vld;
  logic [1:0]  sel;
  logic        clr;

  logic [3:0]  out_a;
  logic [3:0]  val_a;
  logic [31:0] cnt_a;
  logic [31:0] out_b;
  logic [3:0]  val_b;
  logic [7:0]  cnt_b;

  int n_vec = 0;
  int n_err = 0;

  // Reference state, advanced once per rising edge.
  logic [3:0]  m_out_a;
  logic [31:0] m_out_b;
  logic [3:0]  m_val;
  int          m_cnt_a [4];
  int          m_cnt_b [4];

  typedef struct {
    logic        rst_n;
    logic [7:0]  din;
    logic        vld;
    logic [1:0]  sel;
    logic        clr;
    logic [31:0] exp_out;
    logic [3:0]  exp_val;
  } vec_t;

  vec_t tbl [7];

  always #5 clk = ~clk;

  demux_1_to_4 #(.WIDTH(1), .CNT_W(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in(din[0]), .in_valid(vld), .select(sel),
    .out(out_a), .out_valid(val_a), .cnt(cnt_a), .cnt_clr(clr)
  );

  demux_1_to_4 #(.WIDTH(8), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in(din), .in_valid(vld), .select(sel),
    .out(out_b), .out_valid(val_b), .cnt(cnt_b), .cnt_clr(clr)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [7:0] d, input logic v,
                       input logic [1:0] s, input logic c);
    rst_n = r; din = d; vld = v; sel = s; clr = c;
  endtask

  task automatic model_update();
    if (!rst_n) begin
      m_out_a = '0;
      m_out_b = '0;
      m_val   = '0;
      for (int k = 0; k < 4; k++) begin
        m_cnt_a[k] = 0;
        m_cnt_b[k] = 0;
      end
    end else begin
      m_out_a = 4'(din[0]) << sel;
      m_out_b = 32'(din) << (8 * int'(sel));
      m_val   = vld ? (4'b0001 << sel) : 4'b0000;
      for (int k = 0; k < 4; k++) begin
        if (clr) begin
          m_cnt_a[k] = 0;
          m_cnt_b[k] = 0;
        end else if (vld && int'(sel) == k) begin
          if (m_cnt_a[k] < 255) m_cnt_a[k]++;
          if (m_cnt_b[k] < 3)   m_cnt_b[k]++;
        end
      end
    end
  endtask

  task automatic chk_all();
    logic [31:0] ea;
    logic [7:0]  eb;
    for (int k = 0; k < 4; k++) begin
      ea[k*8 +: 8] = 8'(m_cnt_a[k]);
      eb[k*2 +: 2] = 2'(m_cnt_b[k]);
    end
    chk("out_a", 64'(out_a), 64'(m_out_a));
    chk("val_a", 64'(val_a), 64'(m_val));
    chk("cnt_a", 64'(cnt_a), 64'(ea));
    chk("out_b", 64'(out_b), 64'(m_out_b));
    chk("val_b", 64'(val_b), 64'(m_val));
    chk("cnt_b", 64'(cnt_b), 64'(eb));
  endtask

  // Advance one clock, update the reference, then sample away from the edge.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    chk_all();
  endtask

  initial begin
    tbl[0] = '{1'b0, 8'hA5, 1'b1, 2'd1, 1'b0, 32'h0000_0000, 4'b0000};
    tbl[1] = '{1'b1, 8'hA5, 1'b1, 2'd1, 1'b0, 32'h0000_A500, 4'b0010};
    tbl[2] = '{1'b1, 8'h3C, 1'b0, 2'd3, 1'b0, 32'h3C00_0000, 4'b0000};
    tbl[3] = '{1'b1, 8'hFF, 1'b1, 2'd0, 1'b0, 32'h0000_00FF, 4'b0001};
    tbl[4] = '{1'b1, 8'h81, 1'b1, 2'd2, 1'b1, 32'h0081_0000, 4'b0100};
    tbl[5] = '{1'b1, 8'h00, 1'b1, 2'd3, 1'b0, 32'h0000_0000, 4'b1000};
    tbl[6] = '{1'b1, 8'h5A, 1'b0, 2'd0, 1'b0, 32'h0000_005A, 4'b0000};

    // Reset held with live inputs: everything stays zero.
    drive(1'b0, 8'h01, 1'b1, 2'd2, 1'b0);
    repeat (3) begin
      step();
      chk("rst_out", 64'(out_a), 64'h0);
      chk("rst_cnt", 64'(cnt_a), 64'h0);
    end
    drive(1'b1, 8'h01, 1'b1, 2'd2, 1'b0);
    step();
    chk("rel_lane2", 64'(out_a), 64'h4);
    chk("rel_valid", 64'(val_a), 64'h4);

    // Sweep every select with the data bit toggling.
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 7; c++) begin
        drive(1'b1, {7'b0, ~din[0]}, 1'b1, 2'(s), 1'b0);
        step();
      end
    end

    // Select 1 -> 2 with data held high: lanes swap on the same edge.
    drive(1'b1, 8'h01, 1'b1, 2'd1, 1'b0);
    step();
    chk("sw_lane1", 64'(out_a), 64'h2);
    sel = 2'd2;
    step();
    chk("sw_lane2", 64'(out_a), 64'h4);

    // Unqualified data still steers but raises no valid and no count.
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, {7'b0, ~din[0]}, 1'b0, 2'd3, 1'b0);
      step();
      chk("nv_valid", 64'(val_a), 64'h0);
    end

    // Narrow counter saturation, clear priority, restart.
    drive(1'b1, 8'h11, 1'b0, 2'd0, 1'b1);
    step();
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 8'(c), 1'b1, 2'd0, 1'b0);
      step();
    end
    chk("sat_cnt0", 64'(cnt_b[1:0]), 64'd3);
    drive(1'b1, 8'h22, 1'b1, 2'd0, 1'b1);
    step();
    chk("clr_cnt0", 64'(cnt_b[1:0]), 64'd0);
    drive(1'b1, 8'h33, 1'b1, 2'd0, 1'b0);
    step();
    chk("inc_cnt0", 64'(cnt_b[1:0]), 64'd1);

    // Directed table against hand-computed wide-lane values.
    foreach (tbl[i]) begin
      drive(tbl[i].rst_n, tbl[i].din, tbl[i].vld, tbl[i].sel, tbl[i].clr);
      step();
      chk($sformatf("tbl%0d_out", i), 64'(out_b), 64'(tbl[i].exp_out));
      chk($sformatf("tbl%0d_val", i), 64'(val_b), 64'(tbl[i].exp_val));
    end

    // Random traffic with rare resets and clears.
    for (int c = 0; c < 1500; c++) begin
      drive(($urandom_range(0, 99) != 0), 8'($urandom), 1'($urandom),
            2'($urandom), ($urandom_range(0, 63) == 0));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
